// File: rtl/vector_loader.sv
//------------------------------------------------------------------------------
// vector_loader
//
// Assembles UART receive bytes into DATA_W-bit words (little-endian: first
// byte lands in the LSB) and writes one vector of VEC_LEN words into a
// host-selected bank out of NUM_BANKS block-RAM port-A interfaces.
//
// Optional feature: define LOADER_TIMEOUT_EN to build an inter-byte timeout
// (TIMEOUT_CYCLES) that aborts a stalled load with an error pulse.
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   rx_data        received UART byte, valid with rx_ready
//   rx_ready       one-cycle pulse, byte available
//   load_req       one-cycle pulse, start loading bank bank_sel
//   bank_sel       target bank, sampled with load_req
//   en             one-hot BRAM port-A enable (one bit per bank)
//   we             BRAM write enable
//   addr           BRAM write address
//   din            BRAM write data
//   busy           high while a load is in progress
//   done           one-cycle pulse, vector complete
//   error          one-cycle pulse, rejected request or timeout
//   words_loaded   words written in the current/last load
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module vector_loader #(
  parameter int NUM_BANKS = 2,
  parameter int VEC_LEN   = 1024,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = $clog2(VEC_LEN),
  parameter int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
`ifdef LOADER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1_000_000
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_ready,
  input  logic                 load_req,
  input  logic [BANK_W-1:0]    bank_sel,
  output logic [NUM_BANKS-1:0] en,
  output logic                 we,
  output logic [ADDR_W-1:0]    addr,
  output logic [DATA_W-1:0]    din,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [ADDR_W:0]      words_loaded
);

  localparam int BPW  = DATA_W / 8;
  localparam int BC_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(BPW - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(VEC_LEN - 1);

  typedef enum logic [1:0] {IDLE, LOAD, FINISH} state_t;

  state_t                state_q, state_n;
  logic [BANK_W-1:0]     bank_q, bank_n;
  logic [ADDR_W-1:0]     idx_q, idx_n;
  logic [BC_W-1:0]       bcnt_q, bcnt_n;
  logic [DATA_W-1:0]     asm_q, asm_n;
  logic [NUM_BANKS-1:0]  en_n;
  logic                  we_n, busy_n, done_n, error_n;
  logic [ADDR_W-1:0]     addr_n;
  logic [DATA_W-1:0]     din_n;
  logic [ADDR_W:0]       wl_n;
  logic                  bank_ok;

`ifdef LOADER_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] tmo_q, tmo_n;
`endif

  // Zero-extend so an out-of-range select is representable even when
  // NUM_BANKS is a power of two.
  assign bank_ok = ({1'b0, bank_sel} < (BANK_W + 1)'(NUM_BANKS));

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_n = state_q;
    bank_n  = bank_q;
    idx_n   = idx_q;
    bcnt_n  = bcnt_q;
    asm_n   = asm_q;
    en_n    = '0;
    we_n    = 1'b0;
    addr_n  = addr;
    din_n   = din;
    busy_n  = busy;
    done_n  = 1'b0;
    error_n = 1'b0;
    wl_n    = words_loaded;
`ifdef LOADER_TIMEOUT_EN
    tmo_n   = tmo_q;
`endif

    unique case (state_q)
      IDLE: begin
        busy_n = 1'b0;
        if (load_req) begin
          if (bank_ok) begin
            bank_n  = bank_sel;
            idx_n   = '0;
            bcnt_n  = '0;
            asm_n   = '0;
            wl_n    = '0;
            busy_n  = 1'b1;
            state_n = LOAD;
`ifdef LOADER_TIMEOUT_EN
            tmo_n   = '0;
`endif
          end else begin
            error_n = 1'b1;
          end
        end
      end

      LOAD: begin
        if (rx_ready) begin
`ifdef LOADER_TIMEOUT_EN
          tmo_n = '0;
`endif
          // Bytes are placed by position, so the word written out below
          // already contains the byte arriving in this same cycle.
          asm_n[int'(bcnt_q) * 8 +: 8] = rx_data;
          if (bcnt_q == LAST_BYTE) begin
            bcnt_n = '0;
            en_n   = NUM_BANKS'(1) << bank_q;
            we_n   = 1'b1;
            addr_n = idx_q;
            din_n  = asm_n;
            idx_n  = idx_q + ADDR_W'(1);
            wl_n   = words_loaded + (ADDR_W + 1)'(1);
            if (idx_q == LAST_WORD) state_n = FINISH;
          end else begin
            bcnt_n = bcnt_q + BC_W'(1);
          end
        end
`ifdef LOADER_TIMEOUT_EN
        else if (tmo_q == TO_LAST) begin
          // Stalled sender: drop the partial word, keep words_loaded.
          error_n = 1'b1;
          busy_n  = 1'b0;
          bcnt_n  = '0;
          asm_n   = '0;
          state_n = IDLE;
        end else begin
          tmo_n = tmo_q + TO_W'(1);
        end
`endif
      end

      FINISH: begin
        // busy stays high through the done cycle and drops from IDLE.
        done_n  = 1'b1;
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (!rst_n) begin
      state_q      <= IDLE;
      bank_q       <= '0;
      idx_q        <= '0;
      bcnt_q       <= '0;
      asm_q        <= '0;
      en           <= '0;
      we           <= 1'b0;
      addr         <= '0;
      din          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
`ifdef LOADER_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_n;
      bank_q       <= bank_n;
      idx_q        <= idx_n;
      bcnt_q       <= bcnt_n;
      asm_q        <= asm_n;
      en           <= en_n;
      we           <= we_n;
      addr         <= addr_n;
      din          <= din_n;
      busy         <= busy_n;
      done         <= done_n;
      error        <= error_n;
      words_loaded <= wl_n;
`ifdef LOADER_TIMEOUT_EN
      tmo_q        <= tmo_n;
`endif
    end
  end

endmodule

// File: tb/tb_vector_loader.sv
//------------------------------------------------------------------------------
// tb_vector_loader
//
// Directed bench for vector_loader with NUM_BANKS=2, VEC_LEN=4, DATA_W=16.
// BANK_W is widened to 2 so that an out-of-range bank (2) can be requested.
// Write strobes are logged at the falling edge; checks run 1 ns after the
// rising edge.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_vector_loader;

  localparam int NUM_BANKS = 2;
  localparam int VEC_LEN   = 4;
  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 2;
  localparam int BANK_W    = 2;

  logic              clk;
  logic              rst_n;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              load_req;
  logic [BANK_W-1:0] bank_sel;
  logic [1:0]        en;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  vector_loader #(
    .NUM_BANKS (NUM_BANKS),
    .VEC_LEN   (VEC_LEN),
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .BANK_W    (BANK_W)
`ifdef LOADER_TIMEOUT_EN
    , .TIMEOUT_CYCLES (50)
`endif
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .load_req     (load_req),
    .bank_sel     (bank_sel),
    .en           (en),
    .we           (we),
    .addr         (addr),
    .din          (din),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe / pulse log
  int          cyc = 0;
  logic [1:0]  q_en[$];
  logic [1:0]  q_addr[$];
  logic [15:0] q_din[$];
  int          done_cnt = 0;
  int          err_cnt  = 0;
  int          en_cnt   = 0;
  int          we_cyc   = 0;
  int          done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we) begin
      q_en.push_back(en);
      q_addr.push_back(addr);
      q_din.push_back(din);
      we_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (error) err_cnt++;
    if (|en)   en_cnt++;
  end

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic req(input logic [BANK_W-1:0] b);
    bank_sel = b;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic clear_log();
    q_en.delete();
    q_addr.delete();
    q_din.delete();
    done_cnt = 0;
    err_cnt  = 0;
    en_cnt   = 0;
  endtask

  // Watchdog: the directed sequence is a few hundred cycles.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] exp_words[4];
    int gap;

    rst_n = 1'b0; rx_data = '0; rx_ready = 1'b0; load_req = 1'b0; bank_sel = '0;
    #12;
    // ---------------- reset state ----------------
    check("rst_en",   32'(en), 32'h0);
    check("rst_we",   32'(we), 32'h0);
    check("rst_addr", 32'(addr), 32'h0);
    check("rst_din",  32'(din), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err",  32'(error), 32'h0);
    check("rst_wl",   32'(words_loaded), 32'h0);
    rst_n = 1'b1;
    tick();

    // ---------------- full load into bank 1 ----------------
    clear_log();
    req(1);
    check("t1_busy_rise", 32'(busy), 32'h1);
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    check("t1_last_we",   32'(we), 32'h1);
    check("t1_last_en",   32'(en), 32'h2);
    check("t1_last_addr", 32'(addr), 32'h3);
    check("t1_last_din",  32'(din), 32'h0807);
    tick();
    check("t1_done",      32'(done), 32'h1);
    check("t1_we_pulse",  32'(we), 32'h0);
    check("t1_busy_done", 32'(busy), 32'h1);
    tick();
    check("t1_done_pulse", 32'(done), 32'h0);
    check("t1_busy_fall",  32'(busy), 32'h0);
    check("t1_wl",         32'(words_loaded), 32'h4);
    check("t1_nwrites",    32'(q_din.size()), 32'h4);
    exp_words = '{16'h0201, 16'h0403, 16'h0605, 16'h0807};
    for (int i = 0; i < 4 && i < q_din.size(); i++) begin
      check($sformatf("t1_en%0d", i),   32'(q_en[i]), 32'h2);
      check($sformatf("t1_addr%0d", i), 32'(q_addr[i]), 32'(i));
      check($sformatf("t1_din%0d", i),  32'(q_din[i]), 32'(exp_words[i]));
    end
    check("t1_done_cnt", 32'(done_cnt), 32'h1);
    check("t1_done_lat", 32'(done_cyc - we_cyc), 32'h1);

    // ---------------- bytes while idle, then load bank 0 ----------------
    clear_log();
    send_byte(8'hEE);
    send_byte(8'hFF);
    tick();
    check("t2_idle_writes", 32'(q_din.size()), 32'h0);
    check("t2_idle_wl",     32'(words_loaded), 32'h4);
    req(0);
    check("t2_wl_clear", 32'(words_loaded), 32'h0);
    for (int i = 1; i <= 8; i++) send_byte(8'(8'h11 * i));
    tick();
    tick();
    check("t2_nwrites", 32'(q_din.size()), 32'h4);
    if (q_din.size() > 0) begin
      check("t2_en0",   32'(q_en[0]), 32'h1);
      check("t2_addr0", 32'(q_addr[0]), 32'h0);
      check("t2_din0",  32'(q_din[0]), 32'h2211);
    end
    check("t2_done_cnt", 32'(done_cnt), 32'h1);
    check("t2_wl",       32'(words_loaded), 32'h4);

    // ---------------- invalid bank ----------------
    clear_log();
    req(2);
    check("t3_error", 32'(error), 32'h1);
    check("t3_busy",  32'(busy), 32'h0);
    tick();
    check("t3_err_pulse", 32'(error), 32'h0);
    check("t3_busy2",     32'(busy), 32'h0);
    check("t3_en_quiet",  32'(en_cnt), 32'h0);
    check("t3_err_cnt",   32'(err_cnt), 32'h1);

    // ---------------- async reset mid-load ----------------
    clear_log();
    req(1);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    check("t4_pre_busy", 32'(busy), 32'h1);
    check("t4_pre_wl",   32'(words_loaded), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("t4_rst_busy", 32'(busy), 32'h0);
    check("t4_rst_wl",   32'(words_loaded), 32'h0);
    check("t4_rst_addr", 32'(addr), 32'h0);
    check("t4_rst_din",  32'(din), 32'h0);
    check("t4_rst_en",   32'(en), 32'h0);
    #2 rst_n = 1'b1;
    tick();
    clear_log();
    req(0);
    send_byte(8'hAA);
    send_byte(8'hBB);
    tick();
    check("t4_nwrites", 32'(q_din.size()), 32'h1);
    if (q_din.size() > 0) begin
      check("t4_en0",   32'(q_en[0]), 32'h1);
      check("t4_addr0", 32'(q_addr[0]), 32'h0);
      check("t4_din0",  32'(q_din[0]), 32'hBBAA);
    end
    for (int i = 0; i < 6; i++) send_byte(8'h00);
    tick();
    tick();
    check("t4_busy_end", 32'(busy), 32'h0);

    // ---------------- load_req mid-load is ignored ----------------
    clear_log();
    req(1);
    for (int i = 1; i <= 3; i++) send_byte(8'(i));
    req(0);
    check("t5_busy", 32'(busy), 32'h1);
    check("t5_noerr", 32'(error), 32'h0);
    for (int i = 4; i <= 8; i++) send_byte(8'(i));
    tick();
    tick();
    check("t5_nwrites", 32'(q_din.size()), 32'h4);
    for (int i = 0; i < 4 && i < q_din.size(); i++) begin
      check($sformatf("t5_en%0d", i),  32'(q_en[i]), 32'h2);
      check($sformatf("t5_din%0d", i), 32'(q_din[i]), 32'(exp_words[i]));
    end
    check("t5_err_cnt",  32'(err_cnt), 32'h0);
    check("t5_done_cnt", 32'(done_cnt), 32'h1);

    // ---------------- stalled sender ----------------
    clear_log();
    req(0);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    gap = 0;
`ifdef LOADER_TIMEOUT_EN
    while (gap < 60 && !error) begin
      tick();
      gap++;
    end
    check("t6_err_seen", 32'(error), 32'h1);
    check("t6_gap",      32'(gap), 32'd50);
    check("t6_busy",     32'(busy), 32'h0);
    check("t6_wl",       32'(words_loaded), 32'h1);
    tick();
    check("t6_err_pulse", 32'(error), 32'h0);
    check("t6_no_done",   32'(done_cnt), 32'h0);
`else
    while (gap < 60) begin
      tick();
      gap++;
    end
    check("t6_busy_hold", 32'(busy), 32'h1);
    check("t6_no_err",    32'(err_cnt), 32'h0);
    check("t6_no_done",   32'(done_cnt), 32'h0);
    check("t6_wl",        32'(words_loaded), 32'h1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
